// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache controller and its tag/data memory.
package cache_pkg;

   localparam int unsigned CACHE_ADDR_W = 3;
   localparam int unsigned CACHE_DATA_W = 3;
   localparam int unsigned CACHE_LINES  = 4;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      WB_SET,
      WB_STB,
      READ,
      RESP
   } state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU request/response and memory strobe bus of the cache controller.
interface cache_ctrl_if
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = CACHE_ADDR_W,
   parameter int unsigned DATA_W = CACHE_DATA_W
) ();

   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [ADDR_W-1:0] mem_endereco;
   logic              mem_read;
   logic [DATA_W-1:0] mem_out;
   logic [ADDR_W-1:0] mem_enderecoWB;
   logic [DATA_W-1:0] mem_dadoWB;
   logic              mem_WB;

   // master: the CPU together with the memory block
   modport master (
      output req_valid, req_write, req_addr, req_data, mem_out,
      input  req_ready, resp_valid, resp_data,
      input  mem_endereco, mem_read, mem_enderecoWB, mem_dadoWB, mem_WB
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data, mem_out,
      output req_ready, resp_valid, resp_data,
      output mem_endereco, mem_read, mem_enderecoWB, mem_dadoWB, mem_WB
   );

endinterface

// File: rtl/cache_lookup.sv
// Combinational tag compare and victim choice: lowest invalid line, else the round-robin pointer.
module cache_lookup #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned LINES  = 4
) (
   input  logic [LINES-1:0][ADDR_W-1:0] tags,
   input  logic [LINES-1:0]             valid,
   input  logic [$clog2(LINES)-1:0]     ptr,
   input  logic [ADDR_W-1:0]            addr,
   output logic                         hit,
   output logic [$clog2(LINES)-1:0]     hit_idx,
   output logic [$clog2(LINES)-1:0]     victim_idx
);

   localparam int unsigned IDX_W = $clog2(LINES);

   logic found_inv;

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      victim_idx = ptr;
      found_inv  = 1'b0;
      for (int unsigned i = 0; i < LINES; i++) begin
         if (valid[i] && (tags[i] == addr)) begin
            hit     = 1'b1;
            hit_idx = i[IDX_W-1:0];
         end
         if (!valid[i] && !found_inv) begin
            found_inv  = 1'b1;
            victim_idx = i[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Fully associative write-back, write-allocate cache controller with registered outputs.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = CACHE_ADDR_W,
   parameter int unsigned DATA_W = CACHE_DATA_W,
   parameter int unsigned LINES  = CACHE_LINES
) (
   input logic         clock,
   input logic         reset_n,
   cache_ctrl_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(LINES);

   state_t                       state;
   logic [LINES-1:0][ADDR_W-1:0] tags;
   logic [LINES-1:0][DATA_W-1:0] lines;
   logic [LINES-1:0]             valid;
   logic [LINES-1:0]             dirty;
   logic [IDX_W-1:0]             ptr;
   logic [IDX_W-1:0]             victim_q;
   logic [ADDR_W-1:0]            addr_q;
   logic [DATA_W-1:0]            data_q;
   logic                         write_q;

   logic                         hit;
   logic [IDX_W-1:0]             hit_idx;
   logic [IDX_W-1:0]             victim_idx;

   cache_lookup #(
      .ADDR_W (ADDR_W),
      .LINES  (LINES)
   ) u_lookup (
      .tags       (tags),
      .valid      (valid),
      .ptr        (ptr),
      .addr       (addr_q),
      .hit        (hit),
      .hit_idx    (hit_idx),
      .victim_idx (victim_idx)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state              <= IDLE;
         tags               <= '0;
         lines              <= '0;
         valid              <= '0;
         dirty              <= '0;
         ptr                <= '0;
         victim_q           <= '0;
         addr_q             <= '0;
         data_q             <= '0;
         write_q            <= 1'b0;
         bus.req_ready      <= 1'b1;
         bus.resp_valid     <= 1'b0;
         bus.resp_data      <= '0;
         bus.mem_endereco   <= '0;
         bus.mem_read       <= 1'b0;
         bus.mem_enderecoWB <= '0;
         bus.mem_dadoWB     <= '0;
         bus.mem_WB         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q           <= bus.req_addr;
                  data_q           <= bus.req_data;
                  write_q          <= bus.req_write;
                  bus.mem_endereco <= bus.req_addr;
                  bus.req_ready    <= 1'b0;
                  state            <= CHECK;
               end
            end
            CHECK: begin
               victim_q <= victim_idx;
               if (hit) begin
                  if (write_q) begin
                     lines[hit_idx] <= data_q;
                     dirty[hit_idx] <= 1'b1;
                  end
                  bus.resp_data  <= write_q ? data_q : lines[hit_idx];
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end else begin
                  // pointer only advances when it actually supplied the victim
                  if (&valid) begin
                     ptr <= ptr + 1'b1;
                  end
                  if (valid[victim_idx] && dirty[victim_idx]) begin
                     bus.mem_enderecoWB <= tags[victim_idx];
                     bus.mem_dadoWB     <= lines[victim_idx];
                     state              <= WB_SET;
                  end else if (!write_q) begin
                     bus.mem_read <= 1'b1;
                     state        <= READ;
                  end else begin
                     tags[victim_idx]  <= addr_q;
                     lines[victim_idx] <= data_q;
                     valid[victim_idx] <= 1'b1;
                     dirty[victim_idx] <= 1'b1;
                     bus.resp_data     <= data_q;
                     bus.resp_valid    <= 1'b1;
                     state             <= RESP;
                  end
               end
            end
            WB_SET: begin
               bus.mem_WB <= 1'b1;
               state      <= WB_STB;
            end
            WB_STB: begin
               bus.mem_WB <= 1'b0;
               if (write_q) begin
                  tags[victim_q]  <= addr_q;
                  lines[victim_q] <= data_q;
                  valid[victim_q] <= 1'b1;
                  dirty[victim_q] <= 1'b1;
                  bus.resp_data   <= data_q;
                  bus.resp_valid  <= 1'b1;
                  state           <= RESP;
               end else begin
                  valid[victim_q] <= 1'b0;
                  bus.mem_read    <= 1'b1;
                  state           <= READ;
               end
            end
            READ: begin
               bus.mem_read    <= 1'b0;
               tags[victim_q]  <= addr_q;
               lines[victim_q] <= bus.mem_out;
               valid[victim_q] <= 1'b1;
               dirty[victim_q] <= 1'b0;
               bus.resp_data   <= bus.mem_out;
               bus.resp_valid  <= 1'b1;
               state           <= RESP;
            end
            RESP: begin
               bus.resp_valid <= 1'b0;
               bus.req_ready  <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: a reference cache model predicts data, latency and memory strobes.
module tb_cache_ctrl;
   import cache_pkg::*;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 3;
   localparam int unsigned NL = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(NL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // memory block seen by the DUT: combinational read, write-back on rising edge
   logic [DW-1:0] mem [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
   assign bus.mem_out = mem[bus.mem_endereco];
   always @(posedge clock) if (bus.mem_WB) mem[bus.mem_enderecoWB] <= bus.mem_dadoWB;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // reference cache model
   logic [DW-1:0] ref_mem [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
   logic [AW-1:0] m_tag   [NL];
   logic [DW-1:0] m_data  [NL];
   bit            m_valid [NL];
   bit            m_dirty [NL];
   int            m_ptr = 0;

   typedef struct {
      int            acc;
      int            lat;
      logic [DW-1:0] data;
      int            n_rd;
      int            rd_off;
      logic [AW-1:0] rd_addr;
      int            n_wb;
      int            wb_off;
      logic [AW-1:0] wb_addr;
      logic [DW-1:0] wb_data;
   } exp_t;

   exp_t exp_q[$];

   function automatic void model_reset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      m_ptr = 0;
   endfunction

   function automatic void model_push(input bit wr, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d, input int acc);
      exp_t e;
      int   h = -1;
      int   v = -1;
      e = '{default: 0};
      e.acc = acc;
      for (int i = 0; i < NL; i++) if (m_valid[i] && m_tag[i] == a) h = i;
      if (h >= 0) begin
         e.lat = 2;
         if (wr) begin
            m_data[h]  = d;
            m_dirty[h] = 1'b1;
         end
         e.data = m_data[h];
      end else begin
         for (int i = 0; i < NL; i++) if (!m_valid[i] && v < 0) v = i;
         if (v < 0) begin
            v     = m_ptr;
            m_ptr = (m_ptr + 1) % NL;
         end
         if (m_valid[v] && m_dirty[v]) begin
            e.n_wb           = 1;
            e.wb_off         = 3;
            e.wb_addr        = m_tag[v];
            e.wb_data        = m_data[v];
            ref_mem[m_tag[v]] = m_data[v];
         end
         if (wr) begin
            m_data[v]  = d;
            m_dirty[v] = 1'b1;
            e.lat      = (e.n_wb != 0) ? 4 : 2;
         end else begin
            m_data[v]  = ref_mem[a];
            m_dirty[v] = 1'b0;
            e.n_rd     = 1;
            e.rd_off   = (e.n_wb != 0) ? 4 : 2;
            e.rd_addr  = a;
            e.lat      = (e.n_wb != 0) ? 5 : 3;
         end
         m_tag[v]   = a;
         m_valid[v] = 1'b1;
         e.data     = m_data[v];
      end
      exp_q.push_back(e);
   endfunction

   // monitor: strobe bookkeeping and response scoring
   int            rd_cnt = 0, rd_cyc = 0, wb_cnt = 0, wb_cyc = 0;
   logic [AW-1:0] rd_addr_obs = '0, wb_addr_obs = '0;
   logic [DW-1:0] wb_data_obs = '0;

   always @(negedge clock) begin
      exp_t e;
      if (!reset_n) begin
         rd_cnt = 0;
         wb_cnt = 0;
      end else begin
         if (bus.mem_read || bus.mem_WB) check_eq("strobe_excl", 32'(bus.mem_read & bus.mem_WB), 0);
         if (bus.mem_WB) begin
            wb_cnt++;
            wb_cyc      = cyc;
            wb_addr_obs = bus.mem_enderecoWB;
            wb_data_obs = bus.mem_dadoWB;
         end
         if (bus.mem_read) begin
            rd_cnt++;
            rd_cyc      = cyc;
            rd_addr_obs = bus.mem_endereco;
         end
         if (bus.resp_valid) begin
            check_eq("resp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_eq("resp_data", 32'(bus.resp_data), 32'(e.data));
               check_eq("latency", cyc - e.acc, e.lat);
               check_eq("rd_count", rd_cnt, e.n_rd);
               check_eq("wb_count", wb_cnt, e.n_wb);
               if (e.n_rd != 0 && rd_cnt == 1) begin
                  check_eq("rd_cycle", rd_cyc - e.acc, e.rd_off);
                  check_eq("rd_addr", 32'(rd_addr_obs), 32'(e.rd_addr));
               end
               if (e.n_wb != 0 && wb_cnt == 1) begin
                  check_eq("wb_cycle", wb_cyc - e.acc, e.wb_off);
                  check_eq("wb_addr", 32'(wb_addr_obs), 32'(e.wb_addr));
                  check_eq("wb_data", 32'(wb_data_obs), 32'(e.wb_data));
               end
            end
            rd_cnt = 0;
            wb_cnt = 0;
         end
      end
   end

   task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
      int waited = 0;
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_data  = d;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      if (!bus.req_ready) begin
         check_eq("accept_timeout", 0, 1);
         bus.req_valid = 1'b0;
         return;
      end
      model_push(wr, a, d, cyc);
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(negedge clock);
         if (!hold) bus.req_valid = 1'b0;
         #1;
         if (hold) bus.req_addr = bus.req_addr + 1'b1;
         waited++;
      end
      bus.req_valid = 1'b0;
      if (exp_q.size() != 0) begin
         check_eq("resp_timeout", 32'(exp_q.size()), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      check_eq("rst_req_ready", 32'(bus.req_ready), 1);
      check_eq("rst_resp_valid", 32'(bus.resp_valid), 0);
      check_eq("rst_resp_data", 32'(bus.resp_data), 0);
      check_eq("rst_mem_read", 32'(bus.mem_read), 0);
      check_eq("rst_mem_WB", 32'(bus.mem_WB), 0);
      check_eq("rst_endereco", 32'(bus.mem_endereco), 0);
      check_eq("rst_enderecoWB", 32'(bus.mem_enderecoWB), 0);
      check_eq("rst_dadoWB", 32'(bus.mem_dadoWB), 0);

      do_req(0, 3, 0, 0);   // clean read miss -> 2
      do_req(0, 3, 0, 0);   // hit
      do_req(1, 5, 7, 0);   // clean write miss
      do_req(0, 5, 0, 0);   // hit -> 7
      do_req(0, 4, 0, 0);
      do_req(0, 6, 0, 0);   // cache full
      do_req(0, 2, 0, 0);   // round-robin victim line 0, clean
      do_req(0, 1, 0, 0);   // victim line 1 dirty: write-back 5=7
      do_req(1, 4, 5, 0);   // hit, line 2 becomes dirty

      // read 5 targets dirty line 2; reset lands while in WB_SET
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 3'd5;
      check_eq("abort_accept_ready", 32'(bus.req_ready), 1);
      acc = cyc;
      @(negedge clock);
      bus.req_valid = 1'b0;
      @(negedge clock);
      check_eq("abort_busy_ready", 32'(bus.req_ready), 0);
      check_eq("abort_wb_idle", 32'(bus.mem_WB), 0);
      check_eq("abort_cycle", cyc - acc, 2);
      #1 reset_n = 1'b0;
      @(negedge clock);
      #1 reset_n = 1'b1;
      model_reset();
      check_eq("abort_req_ready", 32'(bus.req_ready), 1);
      check_eq("abort_resp_valid", 32'(bus.resp_valid), 0);
      check_eq("abort_mem_read", 32'(bus.mem_read), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq("abort_no_wb", 32'(bus.mem_WB), 0);
      end
      do_req(0, 5, 0, 0);   // miss after reset, memory holds 7
      do_req(0, 4, 0, 0);   // dirty 5 was discarded, memory holds 3

      // req_valid held high with a moving address through a miss
      do_req(0, 7, 0, 1);
      repeat (4) @(negedge clock);
      check_eq("hold_no_extra", 32'(exp_q.size()), 0);

      for (int i = 0; i < 40; i++) begin
         do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 7)), 0);
      end

      repeat (3) @(negedge clock);
      check_eq("final_idle_ready", 32'(bus.req_ready), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Small fully associative, write-back, write-allocate cache controller that sits directly upstream of the tag/data memory block.
- It accepts single-word CPU requests and answers hits locally.
- On a miss it drives the memory's read strobe (endereco/read/out) and write-back strobe (enderecoWB/dadoWB/WB).
- It owns valid, dirty and replacement state for LINES entries of ADDR_W-bit tag and DATA_W-bit data.

Parameters:
ADDR_W, 3, address/tag width (matches memory endereco)
DATA_W, 3, data word width (matches memory out/dadoWB)
LINES, 4, number of cache lines; power of two, >=2

Ports:
clock  in  1  single clock, all state changes on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  CPU request present
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_data  in  DATA_W  write data
req_ready  out  1  controller can accept (high only in IDLE)
resp_valid  out  1  one-cycle response strobe
resp_data  out  DATA_W  read data, or written data for writes
mem_endereco  out  ADDR_W  memory read address
mem_read  out  1  memory read strobe (memory acts on rising edge)
mem_out  in  DATA_W  memory read data
mem_enderecoWB  out  ADDR_W  write-back address
mem_dadoWB  out  DATA_W  write-back data
mem_WB  out  1  write-back strobe (memory acts on rising edge)

Behaviour:
- Reset (reset_n=0 at a rising edge): all outputs are registered and reset to 0, except req_ready=1.
  - State goes to IDLE; all valid/dirty bits and the replacement pointer are cleared.
  - Applies from any state, mid-operation included; dirty data is discarded and any pending strobe never fires.
- Handshake: a request is accepted on the edge where req_valid&&req_ready (cycle N). The request is latched and req_ready drops.
  - req_valid while busy is ignored and not queued.
- mem_endereco is driven from the latched address from N+1 onward, giving it one cycle of setup before mem_read.
- Hit: tag equal and valid. A line matches at most one tag.
- Victim selection: lowest-index invalid line; if all lines are valid, the line at the round-robin pointer. The pointer increments mod LINES only when it supplies the victim.
- States:
  - IDLE: req_ready=1. On accept go to CHECK.
  - CHECK (N+1): compute hit and victim.
    - Read hit: go to RESP.
    - Write hit: write data, set dirty, go to RESP.
    - Miss with dirty victim: go to WB_SET.
    - Read miss with clean victim: go to READ.
    - Write miss with clean victim: install tag and data, set valid and dirty, go to RESP.
  - WB_SET: load mem_enderecoWB and mem_dadoWB from the victim; mem_WB stays 0. Go to WB_STB.
  - WB_STB: mem_WB=1 for exactly one cycle with address/data held stable. Clear the victim's valid bit. Then go to READ if the request is a read; for a write, install the write data (valid=1, dirty=1) and go to RESP.
  - READ: mem_read=1 for exactly one cycle. On the edge ending READ, capture mem_out into the victim (valid=1, dirty=0) and into resp_data. Go to RESP.
  - RESP: resp_valid=1 for one cycle with resp_data. Go to IDLE; req_ready returns the following cycle.
- Latency from accept cycle N to resp_valid:
  - Hit: N+2.
  - Clean write miss: N+2.
  - Clean read miss: N+3.
  - Dirty write miss: N+4.
  - Dirty read miss: N+5.
- Strobe rules: mem_read and mem_WB are never high in the same cycle. Each strobe is low for at least one cycle between pulses.
- resp_data holds its last value outside RESP.

Decomposition:
- Shared package cache_pkg: state enum (IDLE, CHECK, WB_SET, WB_STB, READ, RESP), and ADDR_W/DATA_W/LINES defaults shared with the memory block.
- One sub-module, cache_lookup: combinational tag compare returning hit, hit index, and victim index from the valid vector and replacement pointer.

Test Plan:
- Reset, then read 3 -> CHECK at N+1; mem_read pulse at N+2 with mem_endereco=3; resp_valid with resp_data=2 at N+3.
- Read 3 again -> hit, resp_data=2 at N+2, no mem_read or mem_WB activity.
- Write 5 with data 7 (clean miss) -> resp_valid with resp_data=7 at N+2, no memory strobes; a later read 5 returns 7 at N+2.
- After reading 3, writing 5=7, reading 4 and reading 6 (cache full), read 2 -> victim is line 0 (clean), no WB; mem_read pulse, resp_data=1. Then read 1 -> victim is line 1 (dirty): mem_WB pulse with enderecoWB=5, dadoWB=7, then mem_read, resp_data=1 at N+5.
- Drive reset_n=0 for one edge while in WB_SET -> next cycle IDLE, req_ready=1, mem_WB never pulses; read 5 then misses (mem_read pulses).
- Hold req_valid=1 through a miss with changing req_addr -> exactly one request is serviced per IDLE acceptance, and the address latched at N is the one used.
